// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO: pops words while space exists, captures the
// registered memory data into a 3-entry buffer and drains it on a valid/ready stream.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_r_clk,
  input  logic                  i_rst_n,
  input  logic                  i_r_empty,
  output logic                  o_r_inc,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [1:0]            o_buf_cnt
);

  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            wr_idx_q, wr_idx_d;
  logic [1:0]            rd_idx_q, rd_idx_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [2:0]            occupancy;
  logic                  pop_fire;
  logic                  deq_fire;

  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Reserve a slot for the word still in flight so the buffer can never overflow.
  assign occupancy   = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign o_r_inc     = i_rst_n & ~i_r_empty & (occupancy < 3'd3);
  assign pop_fire    = o_r_inc & ~i_r_empty;
  assign o_out_valid = (cnt_q != 2'd0);
  assign deq_fire    = o_out_valid & i_out_ready;
  assign o_out_data  = buf_q[rd_idx_q];
  assign o_buf_cnt   = cnt_q;

  always_comb begin
    cnt_d      = cnt_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    inflight_d = pop_fire;
    if (inflight_q) begin
      wr_idx_d = wrap_inc(wr_idx_q);
    end
    if (deq_fire) begin
      rd_idx_d = wrap_inc(rd_idx_q);
    end
    if (inflight_q && !deq_fire) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!inflight_q && deq_fire) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge i_r_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= 2'd0;
      wr_idx_q   <= 2'd0;
      rd_idx_q   <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by cnt_q.
  always_ff @(posedge i_r_clk) begin
    if (inflight_q) begin
      buf_q[wr_idx_q] <= i_rd_data;
    end
  end

  a_no_overflow: assert property (@(posedge i_r_clk) disable iff (!i_rst_n)
    !(inflight_q && (cnt_q == 2'd3)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream: upstream FIFO and output buffer are modelled with
// queues; every cycle the DUT outputs are compared against the queue-based prediction.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       r_empty = 1'b1;
  logic       r_inc;
  logic [7:0] rd_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] buf_cnt;

  fifo_rd_stream #(.DATA_WIDTH(8)) u_dut (
    .i_r_clk    (clk),
    .i_rst_n    (rst_n),
    .i_r_empty  (r_empty),
    .o_r_inc    (r_inc),
    .i_rd_data  (rd_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data),
    .o_buf_cnt  (buf_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;
  int deq_cnt  = 0;

  logic [7:0] fifo_q[$];  // upstream FIFO contents
  logic [7:0] exp_q[$];   // every written word not yet delivered, in order
  logic [7:0] mbuf[$];    // words held in the output buffer
  logic       m_infl = 1'b0;
  logic [7:0] m_word = 8'h00;
  logic       prev_pop = 1'b0;
  logic       prev_deq = 1'b0;
  logic [7:0] prev_word = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One read-clock cycle: retire last cycle's decisions, drive inputs, compare outputs.
  task automatic step(input bit ready);
    int         occ;
    bit         exp_inc;
    logic [7:0] want;
    @(posedge clk);
    #1;
    if (prev_deq) void'(mbuf.pop_front());
    if (m_infl) mbuf.push_back(m_word);
    m_infl    = prev_pop;
    m_word    = prev_word;
    rd_data   = m_infl ? m_word : 8'($urandom);
    r_empty   = (fifo_q.size() == 0);
    out_ready = ready;
    #1;
    occ     = mbuf.size() + int'(m_infl);
    exp_inc = !r_empty && (occ < 3);
    check_eq("r_inc", 32'(r_inc), 32'(exp_inc));
    check_eq("valid", 32'(out_valid), 32'(mbuf.size() != 0));
    check_eq("buf_cnt", 32'(buf_cnt), 32'(mbuf.size()));
    if (mbuf.size() != 0) check_eq("data", 32'(out_data), 32'(mbuf[0]));
    prev_pop = exp_inc;
    if (prev_pop) begin
      prev_word = fifo_q.pop_front();
      pop_cnt++;
    end
    prev_deq = (mbuf.size() != 0) && ready;
    if (prev_deq) begin
      deq_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_deq", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check_eq("order", 32'(out_data), 32'(want));
      end
    end
  endtask

  initial begin
    int first, last, nvalid, npulse, base, guard, sent;
    // Reset with a non-empty FIFO: pops must still be gated off.
    r_empty = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_cnt", 32'(buf_cnt), 32'd0);
    check_eq("rst_inc", 32'(r_inc), 32'd0);
    r_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b1);

    // Single word: one pop pulse, valid two cycles after empty falls.
    push_word(8'hA5);
    first = -1; npulse = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      if (r_inc) npulse++;
      if (out_valid && first < 0) first = i;
    end
    check_eq("single_latency", 32'(first), 32'd2);
    check_eq("single_pulse", 32'(npulse), 32'd1);
    check_eq("single_cnt", 32'(buf_cnt), 32'd0);

    // Burst of 16 with ready held high: no bubbles after the first word.
    for (int i = 0; i < 16; i++) push_word(8'(i));
    first = -1; last = -1; nvalid = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1);
      if (out_valid) begin
        nvalid++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check_eq("burst_valid", 32'(nvalid), 32'd16);
    check_eq("burst_span", 32'(last - first + 1), 32'd16);

    // Backpressure: exactly three pops, then a gapless drain.
    for (int i = 0; i < 8; i++) push_word(8'(i));
    base = pop_cnt;
    repeat (10) step(1'b0);
    check_eq("bp_pops", 32'(pop_cnt - base), 32'd3);
    check_eq("bp_cnt", 32'(buf_cnt), 32'd3);
    check_eq("bp_data", 32'(out_data), 32'h00);
    base = deq_cnt; nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      if (out_valid) nvalid++;
    end
    check_eq("bp_nogap", 32'(nvalid), 32'd8);
    check_eq("bp_drained", 32'(deq_cnt - base), 32'd8);

    // Random ready and random writer.
    sent = 0; guard = 0;
    while ((sent < 200 || exp_q.size() != 0) && guard < 3000) begin
      if (sent < 200 && $urandom_range(99) < 60) begin
        push_word(8'($urandom));
        sent++;
      end
      step($urandom_range(1) == 1);
      guard++;
    end
    check_eq("rand_done", 32'(guard < 3000), 32'd1);

    // Writer stalls after five words.
    repeat (4) step(1'b1);
    base = deq_cnt;
    for (int i = 0; i < 5; i++) push_word(8'(8'h40 + 8'(i)));
    repeat (12) step(1'b1);
    check_eq("stall_deq", 32'(deq_cnt - base), 32'd5);
    check_eq("stall_valid", 32'(out_valid), 32'd0);
    check_eq("stall_inc", 32'(r_inc), 32'd0);
    push_word(8'h77);
    repeat (5) step(1'b1);
    check_eq("stall_resume", 32'(deq_cnt - base), 32'd6);

    // Reset while two words are buffered and one is in flight.
    for (int i = 0; i < 8; i++) push_word(8'(8'h90 + 8'(i)));
    guard = 0;
    do begin
      step(1'b0);
      guard++;
    end while (!(mbuf.size() == 2 && m_infl) && guard < 10);
    check_eq("rst_mid_reached", 32'(guard < 10), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_cnt", 32'(buf_cnt), 32'd0);
    check_eq("rst_mid_inc", 32'(r_inc), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    mbuf.delete();
    m_infl = 1'b0; prev_pop = 1'b0; prev_deq = 1'b0;
    r_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    base = deq_cnt;
    push_word(8'h3C);
    repeat (6) step(1'b1);
    check_eq("rst_mid_first", 32'(deq_cnt - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
